// File: rtl/pci_cycle_decode.sv
// Registered bridge-cycle decoder: captures the CPU address once per cycle, classifies the PCI
// space, generates type-0 IDSEL, flags rejected accesses and retires hung cycles on timeout.
module pci_cycle_decode #(
  parameter int unsigned          BASE_W         = 3,
  parameter logic [BASE_W-1:0]    BRIDGE_BASE    = 3'b100,
  parameter int unsigned          NUM_SLOTS      = 4,
  parameter int unsigned          TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK40,
  input  logic                 RESETn,
  input  logic                 TSn,
  input  logic [31:11]         A,
  input  logic                 MEM_EN,
  input  logic                 IO_EN,
  input  logic                 CYCLE_DONE,
  output logic                 BRIDGE_ENn,
  output logic                 BRIDGE_REG_SPACE,
  output logic [1:0]           PCIAT,
  output logic [NUM_SLOTS-1:0] IDSEL,
  output logic                 DEC_ERR,
  output logic                 TIMEOUT,
  output logic                 BUSY
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDecode, StActive, StRetire} state_e;

  state_e                 state_q, state_d;
  logic [31:11]           addr_q, addr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   en_n_q, en_n_d;
  logic                   reg_sp_q, reg_sp_d;
  logic [1:0]             pciat_q, pciat_d;
  logic [NUM_SLOTS-1:0]   idsel_q, idsel_d;
  logic                   dec_err_q, dec_err_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q, busy_d;

  logic                   win_hit, is_conf0, is_conf1, is_io;
  logic                   dec_err, dec_reg;
  logic [1:0]             dec_pciat;
  logic [4:0]             dev;
  logic [NUM_SLOTS-1:0]   dec_idsel;

  assign win_hit  = (A[31:32-BASE_W] == BRIDGE_BASE);
  assign is_conf0 = (addr_q[28:20] == 9'h1FC);
  assign is_conf1 = (addr_q[28:20] == 9'h1FD);
  assign is_io    = (addr_q[28:21] == 8'hFF);
  assign dev      = addr_q[15:11];

  // Space decode works only on the captured address; window enables are sampled live in DECODE.
  always_comb begin
    dec_pciat = 2'b10;
    dec_err   = 1'b0;
    dec_reg   = 1'b0;
    dec_idsel = '0;
    if (is_conf0) begin
      dec_pciat = 2'b00;
      if (addr_q[19:16] != 4'h0) begin
        dec_err = 1'b1;
      end else if (addr_q[15]) begin
        dec_reg = 1'b1;
      end else if (32'(dev) < NUM_SLOTS) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          dec_idsel[i] = (dev == 5'(i));
        end
      end else begin
        dec_err = 1'b1;
      end
    end else if (is_conf1) begin
      dec_pciat = 2'b01;
    end else if (is_io) begin
      dec_pciat = 2'b11;
      dec_err   = !IO_EN;
    end else begin
      dec_err   = !MEM_EN;
    end
  end

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      en_n_q    <= 1'b1;
      reg_sp_q  <= 1'b0;
      pciat_q   <= 2'b00;
      idsel_q   <= '0;
      dec_err_q <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      en_n_q    <= en_n_d;
      reg_sp_q  <= reg_sp_d;
      pciat_q   <= pciat_d;
      idsel_q   <= idsel_d;
      dec_err_q <= dec_err_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!TSn && win_hit) state_d = StDecode;
      StDecode: state_d = dec_err ? StRetire : StActive;
      StActive: if (CYCLE_DONE || (cnt_q == CntLast)) state_d = StRetire;
      StRetire: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    en_n_d    = en_n_q;
    reg_sp_d  = reg_sp_q;
    pciat_d   = pciat_q;
    idsel_d   = idsel_q;
    dec_err_d = 1'b0;
    timeout_d = 1'b0;
    busy_d    = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (state_d == StDecode) addr_d = A;
      end
      StDecode: begin
        pciat_d = dec_pciat;
        if (dec_err) begin
          dec_err_d = 1'b1;
        end else begin
          en_n_d   = 1'b0;
          idsel_d  = dec_idsel;
          reg_sp_d = dec_reg;
          cnt_d    = '0;
        end
      end
      StActive: begin
        if (state_d == StRetire) begin
          // CYCLE_DONE has priority over an expiring counter
          timeout_d = !CYCLE_DONE;
          en_n_d    = 1'b1;
          idsel_d   = '0;
          reg_sp_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  assign BRIDGE_ENn       = en_n_q;
  assign BRIDGE_REG_SPACE = reg_sp_q;
  assign PCIAT            = pciat_q;
  assign IDSEL            = idsel_q;
  assign DEC_ERR          = dec_err_q;
  assign TIMEOUT          = timeout_q;
  assign BUSY             = busy_q;

endmodule

// File: tb/tb_pci_cycle_decode.sv
// Scoreboard bench for pci_cycle_decode: the driver pushes the expected outcome of every accepted
// cycle, a negedge monitor pops and compares whenever the DUT starts, rejects or retires a cycle.
module tb_pci_cycle_decode;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic        err;
    logic [1:0]  pciat;
    logic [15:0] idsel;
    logic        regsp;
    logic [7:0]  len;
    logic        to;
  } exp_t;

  logic          CLK40, RESETn, TSn, MEM_EN, IO_EN, CYCLE_DONE;
  logic [31:11]  A;
  logic          BRIDGE_ENn, BRIDGE_REG_SPACE, DEC_ERR, TIMEOUT, BUSY;
  logic [1:0]    PCIAT;
  logic [NS-1:0] IDSEL;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  bit   mon_on = 0;

  pci_cycle_decode #(
    .BASE_W        (3),
    .BRIDGE_BASE   (3'b100),
    .NUM_SLOTS     (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK40           (CLK40),
    .RESETn          (RESETn),
    .TSn             (TSn),
    .A               (A),
    .MEM_EN          (MEM_EN),
    .IO_EN           (IO_EN),
    .CYCLE_DONE      (CYCLE_DONE),
    .BRIDGE_ENn      (BRIDGE_ENn),
    .BRIDGE_REG_SPACE(BRIDGE_REG_SPACE),
    .PCIAT           (PCIAT),
    .IDSEL           (IDSEL),
    .DEC_ERR         (DEC_ERR),
    .TIMEOUT         (TIMEOUT),
    .BUSY            (BUSY)
  );

  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: classify the address arithmetically, then derive the cycle outcome.
  function automatic exp_t model(input logic [31:0] addr, input bit mem, input bit io,
                                 input int k, output bit hit);
    exp_t        e;
    int unsigned space, dev, func;
    e     = '0;
    hit   = ((addr >> 29) == 32'd4);
    space = (addr >> 20) & 32'h1FF;
    dev   = (addr >> 11) & 32'h1F;
    func  = (addr >> 16) & 32'hF;
    if (space == 32'h1FC) begin
      e.pciat = 2'd0;
      if (func != 0) e.err = 1'b1;
      else if (dev >= 16) e.regsp = 1'b1;
      else if (dev < NS) e.idsel = 16'(1 << dev);
      else e.err = 1'b1;
    end else if (space == 32'h1FD) begin
      e.pciat = 2'd1;
    end else if (((addr >> 21) & 32'hFF) == 32'hFF) begin
      e.pciat = 2'd3;
      e.err   = !io;
    end else begin
      e.pciat = 2'd2;
      e.err   = !mem;
    end
    e.len = (k <= int'(TO)) ? 8'(k) : 8'(TO);
    e.to  = (k > int'(TO));
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en_n"},   BRIDGE_ENn, 1);
    check({tag, "_regsp"},  BRIDGE_REG_SPACE, 0);
    check({tag, "_pciat"},  PCIAT, 0);
    check({tag, "_idsel"},  IDSEL, 0);
    check({tag, "_dec_err"}, DEC_ERR, 0);
    check({tag, "_timeout"}, TIMEOUT, 0);
    check({tag, "_busy"},   BUSY, 0);
  endtask

  // Starts one cycle; k = ACTIVE cycle in which CYCLE_DONE is raised (k > TO means never).
  task automatic run_txn(input logic [31:0] addr, input bit mem, input bit io, input int k);
    exp_t        e;
    bit          hit;
    logic [31:0] junk;
    e      = model(addr, mem, io, k, hit);
    A      = addr[31:11];
    MEM_EN = mem;
    IO_EN  = io;
    TSn    = 1'b0;
    @(posedge CLK40); #1;
    TSn  = 1'b1;
    junk = $urandom;
    A    = junk[31:11];
    check("busy_after_ts", BUSY, 32'(hit));
    if (!hit) begin
      CYCLE_DONE = 1'b0;
      return;
    end
    CYCLE_DONE = 1'($urandom_range(0, 1));
    exp_q.push_back(e);
    @(posedge CLK40); #1;
    CYCLE_DONE = 1'b0;
    check("en_n_after_decode", BRIDGE_ENn, 32'(e.err));
    check("dec_err_after_decode", DEC_ERR, 32'(e.err));
    if (!e.err) begin
      for (int j = 1; j <= int'(TO); j++) begin
        if (j == k) CYCLE_DONE = 1'b1;
        @(posedge CLK40); #1;
        CYCLE_DONE = 1'b0;
        if (j == k) break;
      end
    end
    check("busy_in_retire", BUSY, 1);
    @(posedge CLK40); #1;
    check("busy_back_idle", BUSY, 0);
  endtask

  task automatic reset_mid_active();
    mon_on = 0;
    A      = 21'h10_0000;
    MEM_EN = 1'b1;
    TSn    = 1'b0;
    @(posedge CLK40); #1;
    TSn = 1'b1;
    @(posedge CLK40); #1;
    check("rst_pre_en_n", BRIDGE_ENn, 0);
    @(posedge CLK40); #1;
    RESETn = 1'b0;
    @(posedge CLK40); #1;
    RESETn = 1'b1;
    check_reset_outputs("rst_mid");
    mon_on = 1;
  endtask

  // Monitor: compares each ACTIVE cycle against the queue head, pops on DEC_ERR or retire.
  bit   prev_en_n = 1'b1;
  int   act_len = 0;
  exp_t f;
  always @(negedge CLK40) begin
    if (!mon_on) begin
      prev_en_n = 1'b1;
    end else begin
      if (DEC_ERR) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dec_err", 1, 0);
        end else begin
          f = exp_q.pop_front();
          check("dec_err_expected", 1, 32'(f.err));
          check("dec_err_en_n", BRIDGE_ENn, 1);
          check("dec_err_idsel", IDSEL, 0);
          check("dec_err_regsp", BRIDGE_REG_SPACE, 0);
        end
      end
      if (!BRIDGE_ENn) begin
        act_len = prev_en_n ? 1 : act_len + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_active", 1, 0);
        end else begin
          f = exp_q[0];
          check("act_pciat", PCIAT, 32'(f.pciat));
          check("act_idsel", IDSEL, 32'(f.idsel));
          check("act_regsp", BRIDGE_REG_SPACE, 32'(f.regsp));
        end
        check("no_timeout_active", TIMEOUT, 0);
      end else if (!prev_en_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          f = exp_q.pop_front();
          check("retire_kind", 0, 32'(f.err));
          check("retire_len", 32'(act_len), 32'(f.len));
          check("retire_timeout", TIMEOUT, 32'(f.to));
          check("retire_idsel", IDSEL, 0);
          check("retire_regsp", BRIDGE_REG_SPACE, 0);
          check("retire_pciat", PCIAT, 32'(f.pciat));
        end
      end else begin
        check("no_timeout_idle", TIMEOUT, 0);
      end
      prev_en_n = BRIDGE_ENn;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rnd, addr;
    int          r;
    RESETn     = 1'b0;
    TSn        = 1'b1;
    A          = '0;
    MEM_EN     = 1'b0;
    IO_EN      = 1'b0;
    CYCLE_DONE = 1'b0;
    repeat (3) @(posedge CLK40);
    #1;
    check_reset_outputs("reset");
    RESETn = 1'b1;
    mon_on = 1;

    run_txn(32'h8000_0000, 1, 0, 5);
    run_txn(32'h9FC0_1000, 1, 1, 3);
    run_txn(32'h9FC0_8000, 1, 1, 2);
    run_txn(32'h9FD0_0000, 0, 0, 1);
    run_txn(32'h9FC0_2800, 1, 1, 1);
    run_txn(32'h9FE0_0000, 1, 0, 1);
    run_txn(32'h2000_0000, 1, 1, 1);
    run_txn(32'h8000_0000, 1, 0, 100);
    run_txn(32'h8000_0000, 1, 0, 8);
    run_txn(32'h8000_0000, 1, 0, 9);
    reset_mid_active();
    run_txn(32'h9FC0_1800, 1, 1, 4);

    for (int t = 0; t < 150; t++) begin
      r   = $urandom_range(0, 4);
      rnd = $urandom;
      case (r)
        0: addr = {3'b100, rnd[28:0]};
        1: addr = 32'h9FC0_0000 | ({27'd0, rnd[4:0]} << 11)
                  | ((rnd[7:6] == 2'b00) ? {12'd0, rnd[11:8], 16'd0} : 32'd0);
        2: addr = {12'h9FD, rnd[19:0]};
        3: addr = {11'b100_1111_1111, rnd[20:0]};
        default: addr = rnd;
      endcase
      run_txn(addr, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(1, 10));
    end

    repeat (3) @(posedge CLK40);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pci_cycle_decode.md
# pci_cycle_decode

Registered, parametrised successor to the bridge address decoder, sitting between the 68040-side cycle start and the PCI bridge sequencer. It samples the address once per bridge cycle and latches the access type, bridge enable and bridge-register select for the life of the cycle. It adds one-hot type-0 IDSEL generation and decode-error detection for absent slots or disabled windows. A timeout retires cycles the bridge never completes.

## Interface
- BASE_W, 3: number of upper address bits compared for the bridge window (A[31:32-BASE_W]).
- BRIDGE_BASE, 3'b100: window match value for A[31:32-BASE_W].
- NUM_SLOTS, 4: populated type-0 devices, 1..16; device d maps to IDSEL[d].
- TIMEOUT_CYCLES, 255: ACTIVE cycles allowed before forced retire; counter width is $clog2(TIMEOUT_CYCLES+1).
- CLK40  in  1  system clock; all logic on the rising edge.
- RESETn  in  1  synchronous, active-low reset.
- TSn  in  1  cycle-start strobe, active low; sampled only in IDLE.
- A  in  [31:11]  CPU address.
- MEM_EN  in  1  PCI memory window enable.
- IO_EN  in  1  PCI I/O window enable.
- CYCLE_DONE  in  1  bridge sequencer has terminated the PCI cycle.
- BRIDGE_ENn  out  1  low while a decoded bridge cycle is ACTIVE.
- BRIDGE_REG_SPACE  out  1  access targets the bridge's own registers.
- PCIAT  out  [1:0]  00 = Config 0, 01 = Config 1, 10 = Memory, 11 = I/O.
- IDSEL  out  [NUM_SLOTS-1:0]  one-hot type-0 device select.
- DEC_ERR  out  1  one-cycle pulse: the access was rejected and no PCI cycle is started.
- TIMEOUT  out  1  one-cycle pulse: the ACTIVE cycle was aborted by timeout.
- BUSY  out  1  state is not IDLE.

## Operation
- States: IDLE, DECODE, ACTIVE, RETIRE.
- IDLE → DECODE requires TSn = 0 and A[31:32-BASE_W] = BRIDGE_BASE. Without a window match, stay in IDLE.
- DECODE captures A into an internal register. All decode uses the captured value.
- Space classification:
  - CONF0: A[28:20] = 9'h1FC.
  - CONF1: A[28:20] = 9'h1FD.
  - IO: A[28:21] = 8'hFF.
  - Memory: everything else.
- CONF0 sub-decode (device dev = A[15:11]):
  - A[19:16] ≠ 0 → error.
  - A[19:15] = 5'b00001 (dev 16–31) → BRIDGE_REG_SPACE = 1, IDSEL = 0.
  - dev < NUM_SLOTS → IDSEL[dev] = 1.
  - Otherwise → error.
- Further errors: Memory with MEM_EN = 0; IO with IO_EN = 0. CONF1 never errors.
- DECODE with an error → pulse DEC_ERR, go to RETIRE. BRIDGE_ENn, IDSEL and BRIDGE_REG_SPACE are never asserted for that cycle.
- DECODE without an error → ACTIVE. Assert BRIDGE_ENn = 0 and drive PCIAT, IDSEL and BRIDGE_REG_SPACE from registers. Clear the timeout counter.
- ACTIVE: all outputs stay stable and the counter increments each cycle.
  - CYCLE_DONE = 1 → RETIRE.
  - Otherwise, counter = TIMEOUT_CYCLES-1 → pulse TIMEOUT, go to RETIRE.
- RETIRE: BRIDGE_ENn = 1, IDSEL = 0, BRIDGE_REG_SPACE = 0. PCIAT holds its last value. Next state is IDLE unconditionally.
- TSn is ignored outside IDLE. CYCLE_DONE is ignored outside ACTIVE.

## Timing
- Reset values (next edge with RESETn = 0, from any state): state IDLE, BRIDGE_ENn = 1, BRIDGE_REG_SPACE = 0, PCIAT = 00, IDSEL = 0, DEC_ERR = 0, TIMEOUT = 0, BUSY = 0, counter = 0.
- Reset mid-cycle: outputs return to reset values on that edge. No DEC_ERR or TIMEOUT pulse is issued.
- Latency: TSn sampled low at edge n → BUSY = 1 after n. Decoded outputs are valid after edge n+1, giving BRIDGE_ENn low two edges after the cycle start.
- CYCLE_DONE sampled high at edge m → BRIDGE_ENn high after m, IDLE after m+1. A new TSn is accepted at edge m+2 at the earliest.
- All outputs are registered; there is no combinational path from inputs to outputs.
- CYCLE_DONE and timeout on the same edge: CYCLE_DONE wins and no TIMEOUT pulse is issued.
- TIMEOUT is asserted after exactly TIMEOUT_CYCLES ACTIVE cycles with no CYCLE_DONE.
- DEC_ERR appears after edge n+1, lasts one cycle, and is followed by one RETIRE cycle.

## Test plan
- Memory access: A = 32'h8000_0000, MEM_EN = 1, TSn pulse, CYCLE_DONE after 5 cycles → BRIDGE_ENn low 2 edges after TSn for 5 cycles, PCIAT = 10, IDSEL = 0, BUSY drops 2 edges after CYCLE_DONE.
- CONF0 slot 2: A = 32'h9FC0_1000 (dev 2), NUM_SLOTS = 4 → PCIAT = 00, IDSEL = 4'b0100, BRIDGE_REG_SPACE = 0.
- Bridge register: A = 32'h9FC0_8000 → PCIAT = 00, BRIDGE_REG_SPACE = 1, IDSEL = 0, BRIDGE_ENn = 0. A = 32'h9FD0_0000 → PCIAT = 01, no error.
- Errors:
  - A = 32'h9FC0_2800 (dev 5) → one DEC_ERR pulse, BRIDGE_ENn stays 1.
  - IO A = 32'h9FE0_0000 with IO_EN = 0 → DEC_ERR.
  - A = 32'h2000_0000 → BUSY stays 0.
- Timeout: TIMEOUT_CYCLES = 8, no CYCLE_DONE → TIMEOUT pulse after 8 ACTIVE cycles, then IDLE. A separate run with CYCLE_DONE on cycle 8 → no TIMEOUT pulse.
- Reset: RESETn low for one edge during ACTIVE → all outputs at reset values on the next edge. The next TSn decodes normally.
